control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
Hardwired control unit that drives the DataPath's control inputs, taking the place of hand-timed stimulus. Runs the fetch sequence T0–T2, then decodes the instruction register and issues the execute steps for register-register ALU ops, MUL/DIV (HI/LO), NOP and HALT. It sits beside DataPath and shares `clock` and `clear`. It reads IR back from the datapath and accepts a memory-ready handshake.

Parameters:
RESET_PC_WAIT, 1, idle cycles after `clear` deasserts before the first T0 (range 1–15)

Ports:
clock  input  1  system clock; all state changes on rising edge
clear  input  1  synchronous, active-high reset
IR  input  32  instruction register contents from DataPath; opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]
mem_ready  input  1  memory read data valid on Mdatain this cycle
stop  input  1  request halt after the current instruction
Rin  output  16  one-hot register load enables, R0in..R15in
Rout  output  16  one-hot register bus drives, R0out..R15out
PCin, PCout, incPC, MARin, MDRin, MDRout, read, IRin, Yin, Zin, ZLowOut, ZHighOut, HIin, LOin  output  1 each  datapath strobes
opcode  output  5  ALU operation select
run  output  1  high while sequencing; low in IDLE and HALT
T  output  3  current step number for debug (0–6)

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT.
- Outputs are Moore: decoded from state and IR only. Every strobe is held for exactly the full cycle of its state. DataPath captures on the rising edge that ends the state.
- Reset: `clear`=1 at a rising edge forces IDLE and the wait counter to 0. It overrides every other input, in any state, including mid-instruction.
- Outputs in IDLE and HALT: all strobes 0, Rin=Rout=0, opcode=0, run=0, T=0.
- IDLE → T0 after RESET_PC_WAIT cycles with `clear` low.
- T0: PCout, MARin, incPC, Zin.
- T1: ZLowOut, PCin, read, MDRin.
  - Stays in T1 while mem_ready=0. Re-loading PC from the unchanged Z is benign.
  - Advances to T2 on the edge where mem_ready=1.
- T2: MDRout, IRin.
- IR is valid from T3 onward. Decode uses the IR input combinationally.
- ALU ops, opcode 00011–01110 (ADD=00011, SUB=00100, AND=00101, OR=00110, then shifts/rotates):
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], opcode=IR[31:27], Zin.
  - T5: ZLowOut, Rin[Ra]; then → T0.
- MUL=01111, DIV=10000:
  - T3: Rout[Ra], Yin.
  - T4: Rout[Rb], opcode=IR[31:27], Zin.
  - T5: ZLowOut, LOin.
  - T6: ZHighOut, HIin; then → T0.
- NOP=11010, and every undefined opcode (00000–00010, 10001–11001, 11100–11111): T3 asserts nothing; then → T0.
- HALT=11011: T3 → HALT. HALT is left only by `clear`.
- `stop`:
  - Sampled at the final step of each instruction (T5, T6 or T3).
  - If 1, the next state is HALT instead of T0.
  - A `stop` pulse in other states is ignored; it is not latched.
- The opcode output is held at IR[31:27] only in T4, and is 0 otherwise. This keeps Z from capturing stale results.
- Rin and Rout are never both nonzero in the same cycle. At most one bit of each is set.
- Ra=Rb or Ra=Rc is legal; same sequence.
- The T output encodes T0..T6 as 0..6.

Test Plan:
- Reset then ADD: `clear` held 2 cycles, mem_ready=1, IR=0x18338000 (ADD R0,R6,R7) → sequence:
  - T0: PCout/MARin/incPC/Zin.
  - T1, then T2.
  - T3: Rout=0x0040 with Yin.
  - T4: Rout=0x0080, opcode=00011, Zin.
  - T5: ZLowOut with Rin=0x0001.
  - Next cycle T0; run=1 throughout.
- Memory stall: mem_ready=0 for 3 cycles in T1 → T1 strobes held for 4 cycles; T2 on the cycle after mem_ready=1.
- MUL: IR=0x79A00000 (MUL R3,R4) →
  - T3: Rout=0x0008, Yin.
  - T4: Rout=0x0010, opcode=01111, Zin.
  - T5: ZLowOut, LOin.
  - T6: ZHighOut, HIin.
  - Then T0.
- HALT and stop:
  - IR=0xD8000000 → after T3, HALT with run=0 and all outputs 0, held 20 cycles.
  - Separately, stop=1 during T5 of an ADD → HALT, no T0.
- Reset mid-instruction: assert `clear` in T4 → next cycle IDLE, all outputs 0. Restarts at T0 after RESET_PC_WAIT cycles.
- Undefined opcode: IR=0xF8000000 → T3 with no strobes, then T0. Rin/Rout mutual exclusion is checked every cycle of all tests.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control unit for the DataPath: fetch T0-T2, then decode IR and
// issue the execute steps for ALU ops, MUL/DIV, NOP and HALT.
module control_sequencer #(
  parameter int RESET_PC_WAIT = 1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  input  logic        stop,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCin,
  output logic        PCout,
  output logic        incPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        read,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLowOut,
  output logic        ZHighOut,
  output logic        HIin,
  output logic        LOin,
  output logic [4:0]  opcode,
  output logic        run,
  output logic [2:0]  T
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;

  logic [4:0]  op;
  logic [3:0]  ra, rb, rc;
  logic        is_alu, is_md, is_halt;
  logic        unused_ir;
  state_t      done_nxt;

  assign op        = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];
  assign is_alu    = (op >= 5'd3) && (op <= 5'd14);
  assign is_md     = (op == 5'd15) || (op == 5'd16);
  assign is_halt   = (op == 5'd27);
  // stop only matters on the last step of an instruction
  assign done_nxt  = stop ? S_HALT : S_T0;

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE) wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (wait_cnt == 4'(RESET_PC_WAIT - 1)) state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1:   if (mem_ready) state_nxt = S_T2;
      S_T2:   state_nxt = S_T3;
      S_T3: begin
        if (is_alu || is_md) state_nxt = S_T4;
        else if (is_halt)    state_nxt = S_HALT;
        else                 state_nxt = done_nxt;
      end
      S_T4:   state_nxt = S_T5;
      S_T5:   state_nxt = is_md ? S_T6 : done_nxt;
      S_T6:   state_nxt = done_nxt;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Rin = '0; Rout = '0;
    PCin = 1'b0; PCout = 1'b0; incPC = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; read = 1'b0; IRin = 1'b0;
    Yin = 1'b0; Zin = 1'b0; ZLowOut = 1'b0; ZHighOut = 1'b0;
    HIin = 1'b0; LOin = 1'b0;
    opcode = '0; run = 1'b1; T = 3'd0;
    case (state)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; incPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        T = 3'd1;
        ZLowOut = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        T = 3'd2;
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        T = 3'd3;
        if (is_alu) begin
          Rout = 16'd1 << rb; Yin = 1'b1;
        end else if (is_md) begin
          Rout = 16'd1 << ra; Yin = 1'b1;
        end
      end
      S_T4: begin
        T = 3'd4;
        if (is_alu || is_md) begin
          Rout   = 16'd1 << (is_md ? rb : rc);
          opcode = op;
          Zin    = 1'b1;
        end
      end
      S_T5: begin
        T = 3'd5;
        ZLowOut = 1'b1;
        if (is_md) LOin = 1'b1;
        else       Rin  = 16'd1 << ra;
      end
      S_T6: begin
        T = 3'd6;
        ZHighOut = 1'b1; HIin = 1'b1;
      end
      default: run = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: vector table plus hand sequences for
// HALT hold and reset mid-instruction.
module tb_control_sequencer;

  localparam int WAIT = 3;

  localparam logic [31:0] I_ADD = 32'h1833_8000;
  localparam logic [31:0] I_MUL = 32'h79A0_0000;
  localparam logic [31:0] I_UND = 32'hF800_0000;
  localparam logic [31:0] I_HLT = 32'hD800_0000;

  // strobe order: PCin PCout incPC MARin MDRin MDRout read IRin Yin Zin ZLowOut ZHighOut HIin LOin
  localparam logic [13:0] S_T0 = 14'h1C10;
  localparam logic [13:0] S_T1 = 14'h2288;
  localparam logic [13:0] S_T2 = 14'h0140;
  localparam logic [13:0] S_Y  = 14'h0020;
  localparam logic [13:0] S_Z  = 14'h0010;
  localparam logic [13:0] S_ZL = 14'h0008;
  localparam logic [13:0] S_ZH = 14'h0004;
  localparam logic [13:0] S_HI = 14'h0002;
  localparam logic [13:0] S_LO = 14'h0001;

  logic        clock = 1'b0;
  logic        clear, mem_ready, stop;
  logic [31:0] IR;
  logic [15:0] Rin, Rout;
  logic        PCin, PCout, incPC, MARin, MDRin, MDRout, read, IRin;
  logic        Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, run;
  logic [4:0]  opcode;
  logic [2:0]  T;

  int tests = 0;
  int fails = 0;

  control_sequencer #(.RESET_PC_WAIT(WAIT)) dut (
    .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready), .stop(stop),
    .Rin(Rin), .Rout(Rout), .PCin(PCin), .PCout(PCout), .incPC(incPC),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .read(read), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .ZLowOut(ZLowOut), .ZHighOut(ZHighOut),
    .HIin(HIin), .LOin(LOin), .opcode(opcode), .run(run), .T(T)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        clr;
    logic [31:0] ir;
    logic        mr;
    logic        stp;
    logic [54:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [54:0] ex(int t, bit r, logic [13:0] s,
                                     logic [15:0] rin, logic [15:0] rout, logic [4:0] op);
    return {3'(t), r, s, rin, rout, op};
  endfunction

  function automatic logic [54:0] obs();
    return {T, run, PCin, PCout, incPC, MARin, MDRin, MDRout, read, IRin,
            Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, Rin, Rout, opcode};
  endfunction

  task automatic add(logic c, logic [31:0] i, logic m, logic s, logic [54:0] e);
    vec_t v;
    v.clr = c; v.ir = i; v.mr = m; v.stp = s; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(string name, logic [54:0] got, logic [54:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  // Rin/Rout exclusivity and one-hotness, every cycle
  always @(negedge clock) begin
    tests++;
    if ((Rin != 0 && Rout != 0) || $countones(Rin) > 1 || $countones(Rout) > 1) begin
      fails++;
      $display("FAIL excl: Rin %h Rout %h want at most one one-hot", Rin, Rout);
    end
  end

  initial begin
    int n;
    logic [54:0] z;
    z = ex(0, 0, 0, 0, 0, 0);
    clear = 1'b1; IR = '0; mem_ready = 1'b0; stop = 1'b0;

    // reset, idle wait, ADD R0,R6,R7
    add(1, 0, 0, 0, z);
    add(1, 0, 0, 0, z);
    add(0, 0, 0, 0, z);
    add(0, 0, 0, 0, z);
    add(0, 0, 0, 0, ex(0, 1, S_T0, 0, 0, 0));
    add(0, 0, 1, 0, ex(1, 1, S_T1, 0, 0, 0));
    add(0, 0, 1, 0, ex(2, 1, S_T2, 0, 0, 0));
    add(0, I_ADD, 1, 0, ex(3, 1, S_Y, 0, 16'h0040, 0));
    add(0, I_ADD, 1, 0, ex(4, 1, S_Z, 0, 16'h0080, 5'd3));
    add(0, I_ADD, 1, 0, ex(5, 1, S_ZL, 16'h0001, 0, 0));
    add(0, I_ADD, 0, 0, ex(0, 1, S_T0, 0, 0, 0));
    // memory stall: T1 held 4 cycles
    add(0, I_ADD, 0, 0, ex(1, 1, S_T1, 0, 0, 0));
    add(0, I_ADD, 0, 0, ex(1, 1, S_T1, 0, 0, 0));
    add(0, I_ADD, 0, 0, ex(1, 1, S_T1, 0, 0, 0));
    add(0, I_ADD, 0, 0, ex(1, 1, S_T1, 0, 0, 0));
    add(0, I_ADD, 1, 0, ex(2, 1, S_T2, 0, 0, 0));
    // MUL R3,R4
    add(0, I_MUL, 1, 0, ex(3, 1, S_Y, 0, 16'h0008, 0));
    add(0, I_MUL, 1, 0, ex(4, 1, S_Z, 0, 16'h0010, 5'd15));
    add(0, I_MUL, 1, 0, ex(5, 1, S_ZL | S_LO, 0, 0, 0));
    add(0, I_MUL, 1, 0, ex(6, 1, S_ZH | S_HI, 0, 0, 0));
    add(0, I_MUL, 1, 0, ex(0, 1, S_T0, 0, 0, 0));
    // undefined opcode acts as NOP
    add(0, I_MUL, 1, 0, ex(1, 1, S_T1, 0, 0, 0));
    add(0, I_MUL, 1, 0, ex(2, 1, S_T2, 0, 0, 0));
    add(0, I_UND, 1, 0, ex(3, 1, 0, 0, 0, 0));
    add(0, I_UND, 1, 0, ex(0, 1, S_T0, 0, 0, 0));
    // stop pulses outside the last step are ignored; stop in T5 halts
    add(0, I_UND, 1, 1, ex(1, 1, S_T1, 0, 0, 0));
    add(0, I_UND, 1, 1, ex(2, 1, S_T2, 0, 0, 0));
    add(0, I_ADD, 1, 0, ex(3, 1, S_Y, 0, 16'h0040, 0));
    add(0, I_ADD, 1, 1, ex(4, 1, S_Z, 0, 16'h0080, 5'd3));
    add(0, I_ADD, 1, 1, ex(5, 1, S_ZL, 16'h0001, 0, 0));
    add(0, I_ADD, 1, 1, z);
    add(0, I_ADD, 1, 0, z);

    for (int i = 0; i < vecs.size(); i++) begin
      clear = vecs[i].clr; IR = vecs[i].ir; mem_ready = vecs[i].mr; stop = vecs[i].stp;
      step();
      check($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end

    // HALT opcode, held for 20 cycles regardless of inputs
    clear = 1'b1; stop = 1'b0; mem_ready = 1'b1; IR = I_HLT;
    step();
    clear = 1'b0;
    n = 0;
    while (!run && n < 20) begin step(); n++; end
    check("halt_wait", 55'(n), 55'(WAIT));
    step(); step();
    step(); check("halt_t3", obs(), ex(3, 1, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0]; stop = i[1];
      step();
      check($sformatf("halt_hold%0d", i), obs(), z);
    end

    // clear in T4 returns to IDLE, then restart after the wait
    stop = 1'b0; mem_ready = 1'b1; IR = I_ADD; clear = 1'b1;
    step();
    clear = 1'b0;
    n = 0;
    while (!run && n < 20) begin step(); n++; end
    check("rst_wait1", 55'(n), 55'(WAIT));
    step(); step(); step();
    step(); check("mid_t4", obs(), ex(4, 1, S_Z, 0, 16'h0080, 5'd3));
    clear = 1'b1;
    step(); check("mid_clear", obs(), z);
    clear = 1'b0;
    n = 0;
    while (!run && n < 20) begin step(); n++; end
    check("rst_wait2", 55'(n), 55'(WAIT));
    check("restart_t0", obs(), ex(0, 1, S_T0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
